// File: rtl/sif_pkg.sv
// Shared types and line-level constants for the serial frame receiver.
package sif_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      STOP = 2'd2
   } sif_rx_state_e;

   localparam logic SIF_START_BIT = 1'b1;
   localparam logic SIF_STOP_BIT  = 1'b0;
   localparam logic SIF_IDLE_LVL  = 1'b0;

endpackage

// File: rtl/sif_fifo.sv
// Small synchronous FIFO with first-word-fall-through read data.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module sif_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       i_push,
   input  logic [WIDTH-1:0]           i_wdata,
   input  logic                       i_pop,
   output logic [WIDTH-1:0]           o_rdata,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH+1)-1:0] o_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_empty   = (r_count == '0);
   assign o_full    = (r_count == CNT_W'(DEPTH));
   assign o_count   = r_count;
   assign o_rdata   = r_mem[r_rd_ptr];
   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);

   // Storage, pointers (natural power-of-2 wrap) and occupancy count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
            r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
         end
         if (w_do_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
      end
   end

endmodule

// File: rtl/sif_frame_rx.sv
// Serial frame receiver: start bit 1, DATA_W bits LSB-first, stop bit 0.
// Good frames are queued in a small FIFO behind a valid/ready port.
module sif_frame_rx
   import sif_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              din,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   input  logic              rx_ready,
   output logic              frame_err,
   output logic              ovf,
   input  logic              clr_ovf,
   output logic              busy
);

   localparam int BCNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam int CNT_W  = $clog2(FIFO_DEPTH+1);
   localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(DATA_W-1);

   sif_rx_state_e     r_state;
   sif_rx_state_e     w_state_nxt;
   logic [BCNT_W-1:0] r_bit_cnt;
   logic [DATA_W-1:0] r_shreg;
   logic              r_frame_err;
   logic              r_ovf;
   logic              w_push;
   logic              w_bad_stop;
   logic              w_pop;
   logic              w_full;
   logic              w_empty;
   logic [CNT_W-1:0]  w_count;
   logic              w_overflow;

   assign rx_valid   = (w_count != '0);
   assign w_pop      = rx_ready && !w_empty;
   assign w_overflow = w_push && w_full && !w_pop;
   assign frame_err  = r_frame_err;
   assign ovf        = r_ovf;
   assign busy       = (r_state != IDLE);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next state plus the stop-bit verdict (push good word or flag error).
   always_comb begin
      w_state_nxt = r_state;
      w_push      = 1'b0;
      w_bad_stop  = 1'b0;
      case (r_state)
         IDLE: if (din == SIF_START_BIT) w_state_nxt = DATA;
         DATA: if (r_bit_cnt == LAST_BIT) w_state_nxt = STOP;
         STOP: begin
            // A 1 here is an error, never a fresh start bit.
            w_state_nxt = IDLE;
            if (din == SIF_STOP_BIT) w_push     = 1'b1;
            else                     w_bad_stop = 1'b1;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Bit counter and LSB-first shift register fill.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bit_cnt <= '0;
         r_shreg   <= '0;
      end else if (r_state == IDLE) begin
         r_bit_cnt <= '0;
      end else if (r_state == DATA) begin
         r_shreg[r_bit_cnt] <= din;
         if (r_bit_cnt != LAST_BIT) r_bit_cnt <= r_bit_cnt + BCNT_W'(1);
      end
   end

   // Error pulse and sticky overflow flag; a new overflow beats a clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_frame_err <= 1'b0;
         r_ovf       <= 1'b0;
      end else begin
         r_frame_err <= w_bad_stop;
         if (w_overflow)   r_ovf <= 1'b1;
         else if (clr_ovf) r_ovf <= 1'b0;
      end
   end

   sif_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_wdata (r_shreg),
      .i_pop   (w_pop),
      .o_rdata (rx_data),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

endmodule

// File: tb/tb_sif_frame_rx.sv
// Randomized + directed bench for sif_frame_rx with a queue-based scoreboard.
module tb_sif_frame_rx;

   localparam int DATA_W = 8;
   localparam int DEPTH  = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              din = 1'b0;
   logic              rx_ready = 1'b0;
   logic              clr_ovf = 1'b0;
   logic [DATA_W-1:0] rx_data;
   logic              rx_valid;
   logic              frame_err;
   logic              ovf;
   logic              busy;

   always #5 clk = ~clk;

   sif_frame_rx #(.DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .din       (din),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .frame_err (frame_err),
      .ovf       (ovf),
      .clr_ovf   (clr_ovf),
      .busy      (busy)
   );

   // Stimulus tags: 0 idle, 1 start, 2 data, 3 good stop, 4 bad stop.
   int                ph = 0;
   logic [DATA_W-1:0] tag_word = '0;
   int                ready_mode = 1;   // 0 never, 1 always, 2 random, 3 only on stop bit
   bit                clr_force = 0;
   bit                clr_rand = 0;

   // Reference model: occupancy count, expected words, expected flags.
   int                m_cnt = 0;
   bit                m_pop;
   bit                m_ovf = 0, m_ferr = 0, m_busy = 0;
   logic [DATA_W-1:0] sb_q[$];
   logic [DATA_W-1:0] m_exp;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model advances on each edge from what the driver presented before it.
   always @(posedge clk) begin
      if (rst_n) begin
         m_pop = (m_cnt > 0) && rx_ready;
         if (ph == 1) m_busy = 1;
         if (ph == 3 || ph == 4) m_busy = 0;
         m_ferr = (ph == 4);
         if (m_pop) m_cnt--;
         if (clr_ovf) m_ovf = 0;
         if (ph == 3) begin
            if (m_cnt < DEPTH) begin
               sb_q.push_back(tag_word);
               m_cnt++;
            end else begin
               m_ovf = 1;
            end
         end
      end
   end

   // Monitor: flags every cycle, data on each handshake.
   always @(negedge clk) begin
      check("rx_valid", {31'd0, rx_valid}, {31'd0, (m_cnt > 0)});
      check("frame_err", {31'd0, frame_err}, {31'd0, m_ferr});
      check("ovf", {31'd0, ovf}, {31'd0, m_ovf});
      check("busy", {31'd0, busy}, {31'd0, m_busy});
      if (rx_valid && rx_ready) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_word: got %0h expected none at %0t", rx_data, $time);
         end else begin
            m_exp = sb_q.pop_front();
            check("rx_data", {24'd0, rx_data}, {24'd0, m_exp});
         end
      end
   end

   task automatic drive(input logic b, input int p);
      din = b;
      ph  = p;
      case (ready_mode)
         0:       rx_ready = 1'b0;
         1:       rx_ready = 1'b1;
         2:       rx_ready = 1'($urandom_range(0, 1));
         default: rx_ready = (p == 3 || p == 4);
      endcase
      clr_ovf = clr_force || (clr_rand && ($urandom_range(0, 9) == 0));
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 0);
   endtask

   task automatic send_frame(input logic [DATA_W-1:0] w, input bit bad);
      tag_word = w;
      drive(1'b1, 1);
      for (int i = 0; i < DATA_W; i++) drive(w[i], 2);
      drive(bad, bad ? 4 : 3);
   endtask

   task automatic drain();
      ready_mode = 1;
      for (int i = 0; i < 100 && m_cnt > 0; i++) drive(1'b0, 0);
      if (m_cnt > 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL drain_timeout: got %0d words left expected 0", m_cnt);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      din = 1'b0;
      ph = 0;
      m_cnt = 0;
      sb_q.delete();
      m_ovf = 0;
      m_ferr = 0;
      m_busy = 0;
      #2;
      check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
      check("rst_rx_data", {24'd0, rx_data}, 32'd0);
      check("rst_frame_err", {31'd0, frame_err}, 32'd0);
      check("rst_ovf", {31'd0, ovf}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      do_reset();
      idle(2);

      // Single frame, FIFO empty: valid right after the stop-bit edge.
      ready_mode = 0;
      send_frame(8'hA5, 0);
      check("a5_valid", {31'd0, rx_valid}, 32'd1);
      check("a5_data", {24'd0, rx_data}, 32'hA5);
      idle(2);
      drain();

      // Back-to-back frames with the consumer always ready.
      ready_mode = 1;
      send_frame(8'h3C, 0);
      send_frame(8'hC3, 0);
      idle(3);

      // Bad stop bit, then a clean frame.
      send_frame(8'h5A, 1);
      send_frame(8'h01, 0);
      idle(3);

      // Overflow: fifth frame dropped, then clear.
      ready_mode = 0;
      for (int i = 0; i < 5; i++) send_frame(8'(8'h10 + i), 0);
      check("ovf_after_5", {31'd0, ovf}, 32'd1);
      drain();
      clr_force = 1;
      idle(1);
      clr_force = 0;
      idle(1);
      check("ovf_cleared", {31'd0, ovf}, 32'd0);

      // Full FIFO with a pop on the fifth stop edge: nothing dropped.
      ready_mode = 0;
      for (int i = 0; i < 4; i++) send_frame(8'(8'h10 + i), 0);
      ready_mode = 3;
      send_frame(8'h14, 0);
      check("ovf_pop_same_cycle", {31'd0, ovf}, 32'd0);
      drain();

      // Reset mid-frame after the 4th data bit; trailing zeros are ignored.
      ready_mode = 1;
      drive(1'b1, 1);
      drive(1'b1, 2);
      drive(1'b1, 2);
      drive(1'b0, 2);
      drive(1'b1, 2);
      do_reset();
      idle(4);
      send_frame(8'h77, 0);
      idle(3);

      // Randomized traffic.
      clr_rand = 1;
      repeat (300) begin
         ready_mode = ($urandom_range(0, 3) == 0) ? 0 : 2;
         send_frame(8'($urandom), ($urandom_range(0, 5) == 0));
         idle($urandom_range(0, 3));
      end
      clr_rand = 0;
      drain();
      idle(2);
      check("scoreboard_empty", sb_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
